// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the multi-cycle stage sequencer: stage count,
// stage encodings, sequencer state encodings and a one-hot helper.
package stage_sequencer_pkg;

  localparam int NUM_STAGES = 5;
  localparam int STAGE_W    = 3;

  localparam logic [STAGE_W-1:0] STAGE_FETCH  = 3'd0;
  localparam logic [STAGE_W-1:0] STAGE_DECODE = 3'd1;
  localparam logic [STAGE_W-1:0] STAGE_EXEC   = 3'd2;
  localparam logic [STAGE_W-1:0] STAGE_MEM    = 3'd3;
  localparam logic [STAGE_W-1:0] STAGE_WB     = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_ERROR  = 2'd2
  } seq_state_e;

  // One-hot decode of a stage number into the per-stage enable vector.
  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [STAGE_W-1:0] s);
    logic [NUM_STAGES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      oh[i] = (s == STAGE_W'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/stage_sequencer_mem_wait_timer.sv
// Saturating wait counter for memory handshakes. `expired` is high when the
// count has reached MEM_TIMEOUT-1, i.e. on the last blocked cycle allowed.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  // Next count: clear wins, otherwise count up and stop at LAST.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle CPU stage sequencer: walks FETCH..WRITEBACK one instruction at
// a time, holds a stage while a memory handshake is outstanding, and handles
// flush, halt-at-boundary and memory timeout.
//
// Handshake: mem_req (qualified by mem_is_fetch) is a pure decode of
// registered state and stays high until the cycle in which mem_ack=1; that
// cycle completes the transfer and the stage advances on the next edge.
// mem_ack is ignored whenever mem_req=0.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  needs_mem,
  input  logic                  mem_ack,
  input  logic                  flush,
  input  logic                  halt_req,
  output logic [STAGE_W-1:0]    stage,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  mem_req,
  output logic                  mem_is_fetch,
  output logic                  blocked,
  output logic                  retire,
  output logic                  halted,
  output logic                  bus_error
);

  seq_state_e            state_q, state_d;
  logic [STAGE_W-1:0]    stage_q, stage_d;
  logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
  logic                  halted_q, halted_d;
  logic                  bus_error_q, bus_error_d;
  logic                  mem_pending_q, mem_pending_d;
  logic                  halt_pending_q, halt_pending_d;
  logic                  flush_pending_q, flush_pending_d;
  logic                  boundary;
  logic                  run;
  logic                  timer_en;
  logic                  timer_expired;

  assign run = (state_q == ST_RUN);

  // Request/stall decode; mem_req depends on registered state only.
  always_comb begin
    mem_req      = run && ((stage_q == STAGE_FETCH) ||
                           ((stage_q == STAGE_MEM) && mem_pending_q));
    mem_is_fetch = (stage_q == STAGE_FETCH);
    blocked      = run ? (mem_req && !mem_ack) : 1'b1;
    retire       = run && (stage_q == STAGE_WB) && !blocked;
  end

  assign timer_en = run && blocked;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!timer_en),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Next-state: timeout beats flush, flush beats normal advance/wrap.
  always_comb begin
    state_d         = state_q;
    stage_d         = stage_q;
    mem_pending_d   = mem_pending_q;
    halt_pending_d  = halt_pending_q;
    flush_pending_d = flush_pending_q;
    boundary        = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        halt_pending_d = halt_pending_q | halt_req;
        if (blocked) begin
          if (timer_expired) begin
            state_d = ST_ERROR;
          end else if (flush) begin
            flush_pending_d = 1'b1;
          end
        end else if (flush || flush_pending_q) begin
          stage_d         = STAGE_FETCH;
          mem_pending_d   = 1'b0;
          flush_pending_d = 1'b0;
          boundary        = 1'b1;
        end else if (stage_q == STAGE_WB) begin
          stage_d  = STAGE_FETCH;
          boundary = 1'b1;
        end else begin
          stage_d = stage_q + 3'd1;
          if (stage_q == STAGE_EXEC) begin
            mem_pending_d = needs_mem;
          end else if (stage_q == STAGE_MEM) begin
            mem_pending_d = 1'b0;
          end
        end
        // A pending halt diverts the instruction boundary into HALTED.
        if (boundary && halt_pending_q) begin
          state_d        = ST_HALTED;
          halt_pending_d = 1'b0;
        end
      end
      ST_HALTED: begin
        if (!halt_req) begin
          state_d = ST_RUN;
          stage_d = STAGE_FETCH;
        end
      end
      default: begin
        // ERROR is sticky until reset.
      end
    endcase
    stage_en_d  = (state_d == ST_RUN) ? stage_onehot(stage_d) : '0;
    halted_d    = (state_d == ST_HALTED);
    bus_error_d = (state_d == ST_ERROR);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      stage_q         <= STAGE_FETCH;
      stage_en_q      <= stage_onehot(STAGE_FETCH);
      halted_q        <= 1'b0;
      bus_error_q     <= 1'b0;
      mem_pending_q   <= 1'b0;
      halt_pending_q  <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stage_q         <= stage_d;
      stage_en_q      <= stage_en_d;
      halted_q        <= halted_d;
      bus_error_q     <= bus_error_d;
      mem_pending_q   <= mem_pending_d;
      halt_pending_q  <= halt_pending_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign stage     = stage_q;
  assign stage_en  = stage_en_q;
  assign halted    = halted_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus a randomized run, all
// checked against a rule-level reference model of the sequencer.
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic needs_mem = 1'b0;
  logic mem_ack = 1'b0;
  logic flush = 1'b0;
  logic halt_req = 1'b0;
  logic [STAGE_W-1:0]    stage;
  logic [NUM_STAGES-1:0] stage_en;
  logic mem_req, mem_is_fetch, blocked, retire, halted, bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0=running, 1=halted, 2=error.
  int m_state = 0;
  int m_stage = 0;
  int m_timer = 0;
  bit m_pend  = 0;
  bit m_hpend = 0;
  bit m_fpend = 0;

  // Clock.
  always #5 clk = ~clk;

  stage_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .needs_mem    (needs_mem),
    .mem_ack      (mem_ack),
    .flush        (flush),
    .halt_req     (halt_req),
    .stage        (stage),
    .stage_en     (stage_en),
    .mem_req      (mem_req),
    .mem_is_fetch (mem_is_fetch),
    .blocked      (blocked),
    .retire       (retire),
    .halted       (halted),
    .bus_error    (bus_error)
  );

  function automatic bit e_mem_req();
    return (m_state == 0) && ((m_stage == 0) || ((m_stage == 3) && m_pend));
  endfunction

  function automatic bit e_blocked();
    return (m_state != 0) || (e_mem_req() && !mem_ack);
  endfunction

  function automatic bit e_retire();
    return (m_state == 0) && (m_stage == NUM_STAGES - 1) && !e_blocked();
  endfunction

  function automatic logic [NUM_STAGES-1:0] e_stage_en();
    logic [NUM_STAGES-1:0] v;
    v = '0;
    if (m_state == 0) v[m_stage] = 1'b1;
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit blk, bnd, old_h;
    if (rst) begin
      m_state = 0; m_stage = 0; m_timer = 0;
      m_pend = 0; m_hpend = 0; m_fpend = 0;
      return;
    end
    blk = e_blocked();
    if (m_state == 2) return;
    if (m_state == 1) begin
      if (!halt_req) begin m_state = 0; m_stage = 0; end
      return;
    end
    old_h   = m_hpend;
    m_hpend = m_hpend | halt_req;
    if (blk) begin
      if (m_timer == TO - 1) begin
        m_state = 2; m_timer = 0;
      end else begin
        m_timer++;
        if (flush) m_fpend = 1;
      end
      return;
    end
    m_timer = 0;
    bnd = flush || m_fpend || (m_stage == NUM_STAGES - 1);
    if (flush || m_fpend) begin
      m_pend = 0; m_fpend = 0;
    end else if (m_stage == 2) begin
      m_pend = needs_mem;
    end else if (m_stage == 3) begin
      m_pend = 0;
    end
    if (bnd) begin
      m_stage = 0;
      if (old_h) begin m_state = 1; m_hpend = 0; end
    end else begin
      m_stage++;
    end
  endtask

  // Driver: apply inputs, then wait to the sampling point (falling edge).
  task automatic cyc(input logic r, input logic n, input logic a, input logic f, input logic h);
    rst = r; needs_mem = n; mem_ack = a; flush = f; halt_req = h;
    @(negedge clk);
  endtask

  // Driver: take the rising edge and step the model alongside the DUT.
  task automatic adv();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0);
    adv();
  endtask

  task automatic test_reset();
    do_reset();
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (stage !== 3'd0) begin n_fail++; $display("FAIL reset_stage got=%0d exp=0", stage); end
    n_checks++; if (stage_en !== 5'b00001) begin n_fail++; $display("FAIL reset_stage_en got=%b exp=00001", stage_en); end
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL reset_mem_req got=%b exp=1", mem_req); end
    n_checks++; if (mem_is_fetch !== 1'b1) begin n_fail++; $display("FAIL reset_is_fetch got=%b exp=1", mem_is_fetch); end
    n_checks++; if (retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire got=%b exp=0", retire); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_bus_error got=%b exp=0", bus_error); end
    adv();
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1, 0, 0);
      n_checks++; if (stage !== 3'(i % 5)) begin n_fail++; $display("FAIL basic_stage i=%0d got=%0d exp=%0d", i, stage, i % 5); end
      n_checks++; if (retire !== (i % 5 == 4)) begin n_fail++; $display("FAIL basic_retire i=%0d got=%b exp=%b", i, retire, (i % 5 == 4)); end
      n_checks++; if (blocked !== 1'b0) begin n_fail++; $display("FAIL basic_blocked i=%0d got=%b exp=0", i, blocked); end
      adv();
    end
  endtask

  task automatic test_mem_wait();
    int at_mem, n_blk;
    at_mem = 0; n_blk = 0;
    do_reset();
    cyc(0, 0, 1, 0, 0); adv();
    cyc(0, 0, 1, 0, 0); adv();
    cyc(0, 1, 1, 0, 0); adv();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, (i == 3), 0, 0);
      if (stage == 3'd3) at_mem++;
      if (blocked) n_blk++;
      n_checks++; if (mem_is_fetch !== 1'b0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL memwait_req i=%0d got_req=%b got_fetch=%b exp_req=1 exp_fetch=0", i, mem_req, mem_is_fetch); end
      adv();
    end
    n_checks++; if (at_mem != 4) begin n_fail++; $display("FAIL memwait_hold got=%0d exp=4", at_mem); end
    n_checks++; if (n_blk != 3) begin n_fail++; $display("FAIL memwait_blocked got=%0d exp=3", n_blk); end
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (stage !== 3'd4 || retire !== 1'b1) begin n_fail++; $display("FAIL memwait_wb got_stage=%0d got_retire=%b exp=4/1", stage, retire); end
    adv();
  endtask

  task automatic test_flush();
    do_reset();
    cyc(0, 0, 1, 0, 0); adv();
    cyc(0, 0, 1, 0, 0); adv();
    cyc(0, 1, 1, 1, 0);
    n_checks++; if (retire !== 1'b0) begin n_fail++; $display("FAIL flush_exec_retire got=%b exp=0", retire); end
    adv();
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (stage !== 3'd0 || mem_is_fetch !== 1'b1) begin n_fail++; $display("FAIL flush_exec_stage got=%0d exp=0", stage); end
    adv();
    cyc(0, 0, 0, 1, 0); adv();
    cyc(0, 0, 0, 0, 0);
    n_checks++; if (stage !== 3'd0 || blocked !== 1'b1) begin n_fail++; $display("FAIL flush_fetch_hold got_stage=%0d got_blocked=%b exp=0/1", stage, blocked); end
    adv();
    cyc(0, 0, 1, 0, 0); adv();
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (stage !== 3'd0) begin n_fail++; $display("FAIL flush_fetch_restart got=%0d exp=0", stage); end
    adv();
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (stage !== 3'd1) begin n_fail++; $display("FAIL flush_fetch_next got=%0d exp=1", stage); end
    adv();
  endtask

  task automatic test_halt();
    do_reset();
    cyc(0, 0, 1, 0, 0); adv();
    cyc(0, 0, 1, 0, 1); adv();
    cyc(0, 0, 1, 0, 0); adv();
    cyc(0, 0, 1, 0, 0); adv();
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (stage !== 3'd4 || retire !== 1'b1) begin n_fail++; $display("FAIL halt_wb got_stage=%0d got_retire=%b exp=4/1", stage, retire); end
    adv();
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (halted !== 1'b1 || stage_en !== 5'b00000) begin n_fail++; $display("FAIL halt_enter got_halted=%b got_en=%b exp=1/00000", halted, stage_en); end
    n_checks++; if (mem_req !== 1'b0 || blocked !== 1'b1) begin n_fail++; $display("FAIL halt_idle got_req=%b got_blocked=%b exp=0/1", mem_req, blocked); end
    adv();
    cyc(0, 0, 1, 0, 0);
    n_checks++; if (halted !== 1'b0 || stage_en !== 5'b00001 || mem_req !== 1'b1) begin n_fail++; $display("FAIL halt_exit got_halted=%b got_en=%b got_req=%b exp=0/00001/1", halted, stage_en, mem_req); end
    adv();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL timeout_early i=%0d got=%b exp=0", i, bus_error); end
      adv();
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 0);
      n_checks++; if (bus_error !== 1'b1 || mem_req !== 1'b0 || blocked !== 1'b1 || stage_en !== 5'b00000) begin
        n_fail++; $display("FAIL timeout_error i=%0d got_err=%b got_req=%b got_blk=%b got_en=%b exp=1/0/1/00000", i, bus_error, mem_req, blocked, stage_en);
      end
      adv();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(0, 0, 1, 0, 0); adv();
    cyc(0, 0, 1, 0, 0); adv();
    cyc(0, 1, 1, 0, 0); adv();
    cyc(0, 0, 0, 0, 0); adv();
    cyc(0, 0, 0, 0, 0); adv();
    cyc(1, 0, 0, 0, 0); adv();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      n_checks++; if (stage !== 3'd0 || mem_req !== 1'b1 || mem_is_fetch !== 1'b1 || bus_error !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid i=%0d got_stage=%0d got_req=%b got_fetch=%b got_err=%b exp=0/1/1/0", i, stage, mem_req, mem_is_fetch, bus_error);
      end
      adv();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 59) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      n_checks++; if (stage !== 3'(m_stage)) begin n_fail++; $display("FAIL rnd_stage i=%0d got=%0d exp=%0d", i, stage, m_stage); end
      n_checks++; if (stage_en !== e_stage_en()) begin n_fail++; $display("FAIL rnd_stage_en i=%0d got=%b exp=%b", i, stage_en, e_stage_en()); end
      n_checks++; if (mem_req !== e_mem_req()) begin n_fail++; $display("FAIL rnd_mem_req i=%0d got=%b exp=%b", i, mem_req, e_mem_req()); end
      n_checks++; if (mem_is_fetch !== (m_stage == 0)) begin n_fail++; $display("FAIL rnd_is_fetch i=%0d got=%b exp=%b", i, mem_is_fetch, (m_stage == 0)); end
      n_checks++; if (blocked !== e_blocked()) begin n_fail++; $display("FAIL rnd_blocked i=%0d got=%b exp=%b", i, blocked, e_blocked()); end
      n_checks++; if (retire !== e_retire()) begin n_fail++; $display("FAIL rnd_retire i=%0d got=%b exp=%b", i, retire, e_retire()); end
      n_checks++; if (halted !== (m_state == 1)) begin n_fail++; $display("FAIL rnd_halted i=%0d got=%b exp=%b", i, halted, (m_state == 1)); end
      n_checks++; if (bus_error !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_bus_error i=%0d got=%b exp=%b", i, bus_error, (m_state == 2)); end
      adv();
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_mem_wait();
    test_flush();
    test_halt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
